// File: rtl/bootstrap_sequencer.sv
// Boot loader: copies a linear ROM image into per-channel SRAMs, one
// word per READ/SETUP/STROBE/HOLD cycle, then parks in DONE.
module bootstrap_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int ROM_AW     = 19,
  parameter int CHANNELS   = 3,
  parameter logic [CHANNELS*ADDR_WIDTH-1:0] CH_LEN =
    {ADDR_WIDTH'(4096), ADDR_WIDTH'(131071), ADDR_WIDTH'(256)},
  parameter int ROM_WAIT   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAUSE,
  input  logic                  RESTART,
  output logic [ROM_AW-1:0]     ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic [CHANNELS-1:0]   N_WE,
  output logic [3:0]            CHANNEL,
  output logic                  N_BOOTED
);

  typedef enum logic [2:0] {
    LOAD, READ, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            channel_q, channel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]   n_we_q, n_we_d;
  logic                  n_booted_q, n_booted_d;

  logic [ADDR_WIDTH-1:0] cur_len;
  logic [CHANNELS-1:0]   sel;
  logic                  last_ch;

  always_comb begin
    cur_len = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (channel_q == 4'(i)) begin
        cur_len = CH_LEN[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign sel     = CHANNELS'(1) << channel_q;
  assign last_ch = (channel_q == 4'(CHANNELS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      channel_q  <= '0;
      addr_q     <= '0;
      rom_addr_q <= '0;
      data_q     <= '0;
      n_we_q     <= '1;
      n_booted_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      channel_q  <= channel_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
      n_we_q     <= n_we_d;
      n_booted_q <= n_booted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    channel_d  = channel_q;
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    n_we_d     = '1;
    unique case (state_q)
      LOAD: if (!PAUSE) begin
        if (cur_len == '0) begin
          if (last_ch) state_d = DONE;
          else channel_d = channel_q + 4'd1;
        end else begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      // Pausing restarts the ROM wait so data is always fully settled
      READ: if (PAUSE) begin
        cnt_d = '0;
      end else if (cnt_q == 4'(ROM_WAIT)) begin
        data_d  = ROM_DATA;
        state_d = SETUP;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      SETUP: if (!PAUSE) begin
        state_d = STROBE;
        n_we_d  = ~sel;
      end
      STROBE: state_d = HOLD;
      HOLD: if (!PAUSE) begin
        rom_addr_d = rom_addr_q + ROM_AW'(1);
        if (addr_q < cur_len - ADDR_WIDTH'(1)) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = '0;
          state_d = READ;
        end else if (last_ch) begin
          state_d = DONE;
        end else begin
          channel_d = channel_q + 4'd1;
          state_d   = LOAD;
        end
      end
      DONE: if (!PAUSE && RESTART) begin
        channel_d  = '0;
        addr_d     = '0;
        rom_addr_d = '0;
        state_d    = LOAD;
      end
      default: state_d = LOAD;
    endcase
    n_booted_d = (state_d != DONE);
  end

  assign ROM_ADDR = rom_addr_q;
  assign ADDR     = addr_q;
  assign DATA     = data_q;
  assign N_WE     = n_we_q;
  assign CHANNEL  = channel_q;
  assign N_BOOTED = n_booted_q;

endmodule

// File: tb/tb_bootstrap_sequencer.sv
// Directed bench: expected write table replayed under reset, restart,
// pause and mid-strobe reset; plus all-skip and full-length channels.
module tb_bootstrap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        restart = 1'b0;
  logic [18:0] rom_addr;
  logic [7:0]  rom_data;
  logic [16:0] addr;
  logic [7:0]  data;
  logic [2:0]  n_we;
  logic [3:0]  channel;
  logic        n_booted;

  logic [18:0] rom_addr_z;
  logic [16:0] addr_z;
  logic [7:0]  data_z;
  logic [2:0]  n_we_z;
  logic [3:0]  channel_z;
  logic        n_booted_z;

  logic [18:0] rom_addr_b;
  logic [2:0]  addr_b;
  logic [7:0]  data_b;
  logic [0:0]  n_we_b;
  logic [3:0]  channel_b;
  logic        n_booted_b;

  always #5 clk = ~clk;

  assign rom_data = rom_addr[7:0] + 8'hA0;

  bootstrap_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(17), .ROM_AW(19), .CHANNELS(3),
    .CH_LEN({17'd2, 17'd0, 17'd4}), .ROM_WAIT(1)
  ) dut (
    .CLK(clk), .RST(rst), .PAUSE(pause), .RESTART(restart),
    .ROM_ADDR(rom_addr), .ROM_DATA(rom_data), .ADDR(addr),
    .DATA(data), .N_WE(n_we), .CHANNEL(channel), .N_BOOTED(n_booted)
  );

  bootstrap_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(17), .ROM_AW(19), .CHANNELS(3),
    .CH_LEN({17'd0, 17'd0, 17'd0}), .ROM_WAIT(1)
  ) dut_z (
    .CLK(clk), .RST(rst), .PAUSE(pause), .RESTART(restart),
    .ROM_ADDR(rom_addr_z), .ROM_DATA(8'h5A), .ADDR(addr_z),
    .DATA(data_z), .N_WE(n_we_z), .CHANNEL(channel_z),
    .N_BOOTED(n_booted_z)
  );

  bootstrap_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .ROM_AW(19), .CHANNELS(1),
    .CH_LEN(3'd7), .ROM_WAIT(0)
  ) dut_b (
    .CLK(clk), .RST(rst), .PAUSE(pause), .RESTART(restart),
    .ROM_ADDR(rom_addr_b), .ROM_DATA(rom_addr_b[7:0]), .ADDR(addr_b),
    .DATA(data_b), .N_WE(n_we_b), .CHANNEL(channel_b),
    .N_BOOTED(n_booted_b)
  );

  typedef struct {
    int          e;
    logic [2:0]  nwe;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [3:0]  ch;
  } wr_t;

  wr_t exp_wr[6];
  wr_t got[$];

  int edge_cnt;
  int done_edge, done_z, done_b;
  int z_pulses, b_cnt, b_max;
  logic [7:0] b_last;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (n_we != 3'b111) got.push_back('{edge_cnt, n_we, addr, data, channel});
      if (!n_booted && done_edge == 0) done_edge = edge_cnt;
      if (n_we_z != 3'b111) z_pulses++;
      if (!n_booted_z && done_z == 0) done_z = edge_cnt;
      if (n_we_b == 1'b0) begin
        b_cnt++;
        if (int'(addr_b) > b_max) b_max = int'(addr_b);
        b_last = data_b;
      end
      if (!n_booted_b && done_b == 0) done_b = edge_cnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic clear_stats();
    got.delete();
    done_edge = 0;
    done_z = 0;
    done_b = 0;
    z_pulses = 0;
    b_cnt = 0;
    b_max = -1;
    b_last = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    pause = 1'b0;
    restart = 1'b0;
    clear_stats();
    @(negedge clk);
    chk({tag, "_rst_nwe"}, 32'(n_we), 32'h7);
    chk({tag, "_rst_addr"}, 32'(addr), 0);
    chk({tag, "_rst_data"}, 32'(data), 0);
    chk({tag, "_rst_rom"}, 32'(rom_addr), 0);
    chk({tag, "_rst_ch"}, 32'(channel), 0);
    chk({tag, "_rst_nboot"}, 32'(n_booted), 1);
    rst = 1'b0;
  endtask

  task automatic cmp_writes(input string tag, input int off,
                            input int after, input int shift);
    int ee;
    chk({tag, "_count"}, 32'(got.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        ee = exp_wr[i].e + off + ((exp_wr[i].e > after) ? shift : 0);
        chk($sformatf("%s_w%0d_edge", tag, i), got[i].e, ee);
        chk($sformatf("%s_w%0d_nwe", tag, i), 32'(got[i].nwe), 32'(exp_wr[i].nwe));
        chk($sformatf("%s_w%0d_addr", tag, i), 32'(got[i].addr), 32'(exp_wr[i].addr));
        chk($sformatf("%s_w%0d_data", tag, i), 32'(got[i].data), 32'(exp_wr[i].data));
        chk($sformatf("%s_w%0d_ch", tag, i), 32'(got[i].ch), 32'(exp_wr[i].ch));
      end
    end
  endtask

  initial begin
    int r;
    exp_wr[0] = '{4,  3'b110, 17'd0, 8'hA0, 4'd0};
    exp_wr[1] = '{9,  3'b110, 17'd1, 8'hA1, 4'd0};
    exp_wr[2] = '{14, 3'b110, 17'd2, 8'hA2, 4'd0};
    exp_wr[3] = '{19, 3'b110, 17'd3, 8'hA3, 4'd0};
    exp_wr[4] = '{26, 3'b011, 17'd0, 8'hA4, 4'd2};
    exp_wr[5] = '{31, 3'b011, 17'd1, 8'hA5, 4'd2};

    do_reset("boot");
    repeat (40) @(posedge clk);
    #1;
    cmp_writes("boot", 0, 0, 0);
    chk("boot_done_edge", done_edge, 33);
    chk("boot_rom_end", 32'(rom_addr), 6);
    chk("boot_ch_end", 32'(channel), 2);
    chk("boot_nboot", 32'(n_booted), 0);
    chk("zero_done_edge", done_z, 3);
    chk("zero_pulses", z_pulses, 0);
    chk("zero_rom", 32'(rom_addr_z), 0);
    chk("full_writes", b_cnt, 7);
    chk("full_max_addr", b_max, 6);
    chk("full_last_data", 32'(b_last), 6);
    chk("full_done_edge", done_b, 29);
    chk("full_rom_end", 32'(rom_addr_b), 7);

    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    r = edge_cnt;
    restart = 1'b0;
    got.delete();
    done_edge = 0;
    @(negedge clk);
    chk("rs_nboot", 32'(n_booted), 1);
    chk("rs_rom", 32'(rom_addr), 0);
    chk("rs_ch", 32'(channel), 0);
    repeat (5) @(posedge clk);
    #1 restart = 1'b1;
    repeat (2) @(posedge clk);
    #1 restart = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    cmp_writes("rs", r, 0, 0);
    chk("rs_done_edge", done_edge, 33 + r);

    do_reset("prd");
    @(posedge clk);
    #1 pause = 1'b1;
    repeat (7) @(posedge clk);
    #1 pause = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    cmp_writes("prd", 0, 0, 7);
    chk("prd_done_edge", done_edge, 40);

    do_reset("pst");
    repeat (4) @(posedge clk);
    #1 pause = 1'b1;
    repeat (3) @(posedge clk);
    #1 pause = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    cmp_writes("pst", 0, 4, 2);
    chk("pst_done_edge", done_edge, 35);

    do_reset("mrs");
    repeat (26) @(posedge clk);
    #1;
    chk("mrs_pre_nwe", 32'(n_we), 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("mrs_async_nwe", 32'(n_we), 32'h7);
    chk("mrs_async_rom", 32'(rom_addr), 0);
    chk("mrs_async_ch", 32'(channel), 0);
    do_reset("mrs2");
    repeat (40) @(posedge clk);
    #1;
    cmp_writes("mrs", 0, 0, 0);
    chk("mrs_done_edge", done_edge, 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
